// File: rtl/multicycle_main_control.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_main_control
// Brief    : Moore main-control FSM for the multicycle 16-bit datapath; also
//            counts retired instructions.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_main_control #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [3:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_source,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic             rtype,
  output logic             beq,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] instret
);

  localparam logic [3:0] OP_R    = 4'b0000;
  localparam logic [3:0] OP_ADDI = 4'b0001;
  localparam logic [3:0] OP_LW   = 4'b0010;
  localparam logic [3:0] OP_SW   = 4'b0011;
  localparam logic [3:0] OP_BEQ  = 4'b0100;
  localparam logic [3:0] OP_J    = 4'b0101;
  localparam logic [3:0] OP_HALT = 4'b1111;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_EXEC_R = 4'd3,
    S_WB_R   = 4'd4,
    S_EXEC_I = 4'd5,
    S_WB_I   = 4'd6,
    S_ADDR   = 4'd7,
    S_MEM_RD = 4'd8,
    S_MEM_WB = 4'd9,
    S_MEM_WR = 4'd10,
    S_BRANCH = 4'd11,
    S_JUMP   = 4'd12,
    S_HALT   = 4'd13
  } state_t;

  state_t state, state_next;
  logic   retire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      instret <= '0;
    end else begin
      state <= state_next;
      if (retire) instret <= instret + 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    retire     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_source  = 2'b00;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    rtype      = 1'b0;
    beq        = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    halted     = 1'b0;
    illegal    = 1'b0;

    case (state)
      S_IDLE: if (run) state_next = S_FETCH;
      S_FETCH: begin
        // PC+1 is computed by the ALU and committed only when the read lands
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) state_next = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = 2'b10;
        case (opcode)
          OP_R:         state_next = S_EXEC_R;
          OP_ADDI:      state_next = S_EXEC_I;
          OP_LW, OP_SW: state_next = S_ADDR;
          OP_BEQ:       state_next = S_BRANCH;
          OP_J:         state_next = S_JUMP;
          OP_HALT:      state_next = S_HALT;
          default: begin
            illegal    = 1'b1;
            state_next = S_FETCH;
          end
        endcase
      end
      S_EXEC_R: begin
        alu_src_a  = 1'b1;
        rtype      = 1'b1;
        state_next = S_WB_R;
      end
      S_WB_R: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_EXEC_I: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        state_next = S_WB_I;
      end
      S_WB_I: begin
        reg_write  = 1'b1;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_ADDR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        state_next = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        if (mem_ready) state_next = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        if (mem_ready) begin
          retire     = 1'b1;
          state_next = S_FETCH;
        end
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        rtype      = 1'b1;
        beq        = 1'b1;
        pc_source  = 2'b01;
        pc_write   = zero;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_JUMP: begin
        pc_write   = 1'b1;
        pc_source  = 2'b10;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_HALT: halted = 1'b1;
      default: state_next = S_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_main_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_main_control
// Brief    : Vector-table bench with a scoreboard queue for the main control.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_main_control;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       run = 1'b0;
  logic [3:0] opcode = 4'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;

  logic        mem_read, mem_write, ir_write, pc_write, alu_src_a, rtype, beq;
  logic        reg_write, reg_dst, mem_to_reg, halted, illegal;
  logic [1:0]  pc_source, alu_src_b;
  logic [15:0] instret;

  logic        d4_mem_read, d4_mem_write, d4_ir_write, d4_pc_write, d4_alu_src_a;
  logic        d4_rtype, d4_beq, d4_reg_write, d4_reg_dst, d4_mem_to_reg;
  logic        d4_halted, d4_illegal;
  logic [1:0]  d4_pc_source, d4_alu_src_b;
  logic [3:0]  d4_instret;

  multicycle_main_control dut (
    .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .zero(zero),
    .mem_ready(mem_ready), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .pc_write(pc_write), .pc_source(pc_source),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .rtype(rtype), .beq(beq),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .halted(halted), .illegal(illegal), .instret(instret)
  );

  // Narrow-counter instance shares all stimulus to exercise counter wrap
  multicycle_main_control #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .zero(zero),
    .mem_ready(mem_ready), .mem_read(d4_mem_read), .mem_write(d4_mem_write),
    .ir_write(d4_ir_write), .pc_write(d4_pc_write), .pc_source(d4_pc_source),
    .alu_src_a(d4_alu_src_a), .alu_src_b(d4_alu_src_b), .rtype(d4_rtype),
    .beq(d4_beq), .reg_write(d4_reg_write), .reg_dst(d4_reg_dst),
    .mem_to_reg(d4_mem_to_reg), .halted(d4_halted), .illegal(d4_illegal),
    .instret(d4_instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        run;
    logic [3:0]  opcode;
    logic        zero;
    logic        rdy;
    logic [15:0] exp;
    logic [15:0] cnt;
  } vec_t;

  typedef struct {
    string       name;
    logic [15:0] exp;
    logic [15:0] cnt;
  } exp_t;

  vec_t        vecs[$];
  exp_t        sb[$];
  logic [15:0] c;
  int          n_chk = 0;
  int          n_fail = 0;

  wire [15:0] got = {mem_read, mem_write, ir_write, pc_write, pc_source, alu_src_a,
                     alu_src_b, rtype, beq, reg_write, reg_dst, mem_to_reg, halted, illegal};

  function automatic logic [15:0] pk(input logic mr, mw, irw, pcw, input logic [1:0] pcs,
                                     input logic a, input logic [1:0] b,
                                     input logic rt, bq, rw, rd, m2r, h, il);
    return {mr, mw, irw, pcw, pcs, a, b, rt, bq, rw, rd, m2r, h, il};
  endfunction

  task automatic chk(input string nm, input logic [31:0] g, input logic [31:0] e);
    n_chk++;
    if (g !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, g, e);
    end
  endtask

  task automatic add(input string nm, input logic rn, input logic [3:0] op, input logic z,
                     input logic rdy, input logic [15:0] e, input logic rt);
    vecs.push_back('{nm, rn, op, z, rdy, e, c});
    if (rt) c = c + 16'd1;
  endtask

  task automatic fetch(input logic [3:0] op, input int waits);
    for (int i = 0; i < waits; i++)
      add("fetch_wait", 1'b1, op, 1'b0, 1'b0, pk(1,0,0,0,2'b00,0,2'b01,0,0,0,0,0,0,0), 1'b0);
    add("fetch", 1'b1, op, 1'b0, 1'b1, pk(1,0,1,1,2'b00,0,2'b01,0,0,0,0,0,0,0), 1'b0);
    add("decode", 1'b1, op, 1'b0, 1'b1, pk(0,0,0,0,2'b00,0,2'b10,0,0,0,0,0,0,0), 1'b0);
  endtask

  task automatic run_vecs();
    exp_t e;
    foreach (vecs[i]) begin
      run       = vecs[i].run;
      opcode    = vecs[i].opcode;
      zero      = vecs[i].zero;
      mem_ready = vecs[i].rdy;
      sb.push_back('{vecs[i].name, vecs[i].exp, vecs[i].cnt});
      @(negedge clk);
      e = sb.pop_front();
      chk({"outputs ", e.name}, {16'd0, got}, {16'd0, e.exp});
      chk({"instret ", e.name}, {16'd0, instret}, {16'd0, e.cnt});
      chk({"instret4 ", e.name}, {28'd0, d4_instret}, {28'd0, e.cnt[3:0]});
      chk("rd_wr_exclusive", {31'd0, mem_read & mem_write}, 32'd0);
      chk("regw_pcw_exclusive", {31'd0, reg_write & pc_write}, 32'd0);
      @(posedge clk);
      #1;
    end
    vecs.delete();
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {16'd0, got}, 32'd0);
    chk("reset_instret", {16'd0, instret}, 32'd0);
    rst_n = 1'b1;

    c = 16'd0;
    add("idle_hold", 1'b0, 4'd0, 1'b0, 1'b1, 16'd0, 1'b0);
    add("idle_go",   1'b1, 4'd0, 1'b0, 1'b1, 16'd0, 1'b0);
    // R-type
    fetch(4'b0000, 0);
    add("exec_r", 1'b1, 4'b0000, 1'b0, 1'b1, pk(0,0,0,0,2'b00,1,2'b00,1,0,0,0,0,0,0), 1'b0);
    add("wb_r",   1'b1, 4'b0000, 1'b0, 1'b1, pk(0,0,0,0,2'b00,0,2'b00,0,0,1,1,0,0,0), 1'b1);
    // lw with 2 fetch waits and 3 memory waits: 10 cycles
    fetch(4'b0010, 2);
    add("addr_lw", 1'b1, 4'b0010, 1'b0, 1'b1, pk(0,0,0,0,2'b00,1,2'b10,0,0,0,0,0,0,0), 1'b0);
    for (int i = 0; i < 3; i++)
      add("mem_rd_wait", 1'b1, 4'b0010, 1'b0, 1'b0, pk(1,0,0,0,2'b00,0,2'b00,0,0,0,0,0,0,0), 1'b0);
    add("mem_rd", 1'b1, 4'b0010, 1'b0, 1'b1, pk(1,0,0,0,2'b00,0,2'b00,0,0,0,0,0,0,0), 1'b0);
    add("mem_wb", 1'b1, 4'b0010, 1'b0, 1'b1, pk(0,0,0,0,2'b00,0,2'b00,0,0,1,0,1,0,0), 1'b1);
    // beq taken then not taken
    fetch(4'b0100, 0);
    add("branch_z1", 1'b1, 4'b0100, 1'b1, 1'b1, pk(0,0,0,1,2'b01,1,2'b00,1,1,0,0,0,0,0), 1'b1);
    fetch(4'b0100, 0);
    add("branch_z0", 1'b1, 4'b0100, 1'b0, 1'b1, pk(0,0,0,0,2'b01,1,2'b00,1,1,0,0,0,0,0), 1'b1);
    // illegal opcode pulses in DECODE and retires nothing
    add("fetch_ill", 1'b1, 4'b1010, 1'b0, 1'b1, pk(1,0,1,1,2'b00,0,2'b01,0,0,0,0,0,0,0), 1'b0);
    add("decode_ill", 1'b1, 4'b1010, 1'b0, 1'b1, pk(0,0,0,0,2'b00,0,2'b10,0,0,0,0,0,0,1), 1'b0);
    // addi
    fetch(4'b0001, 0);
    add("exec_i", 1'b1, 4'b0001, 1'b0, 1'b1, pk(0,0,0,0,2'b00,1,2'b10,0,0,0,0,0,0,0), 1'b0);
    add("wb_i",   1'b1, 4'b0001, 1'b0, 1'b1, pk(0,0,0,0,2'b00,0,2'b00,0,0,1,0,0,0,0), 1'b1);
    // sw zero-wait
    fetch(4'b0011, 0);
    add("addr_sw", 1'b1, 4'b0011, 1'b0, 1'b1, pk(0,0,0,0,2'b00,1,2'b10,0,0,0,0,0,0,0), 1'b0);
    add("mem_wr",  1'b1, 4'b0011, 1'b0, 1'b1, pk(0,1,0,0,2'b00,0,2'b00,0,0,0,0,0,0,0), 1'b1);
    // 16 jumps: the 4-bit counter must pass 15 -> 0
    for (int j = 0; j < 16; j++) begin
      fetch(4'b0101, 0);
      add("jump", 1'b1, 4'b0101, 1'b0, 1'b1, pk(0,0,0,1,2'b10,0,2'b00,0,0,0,0,0,0,0), 1'b1);
    end
    // sw left stalled in MEM_WR for the reset test
    fetch(4'b0011, 0);
    add("addr_sw2", 1'b1, 4'b0011, 1'b0, 1'b1, pk(0,0,0,0,2'b00,1,2'b10,0,0,0,0,0,0,0), 1'b0);
    add("mem_wr_wait", 1'b1, 4'b0011, 1'b0, 1'b0, pk(0,1,0,0,2'b00,0,2'b00,0,0,0,0,0,0,0), 1'b0);
    run_vecs();

    chk("count_before_reset", {16'd0, instret}, 32'd22);
    mem_ready = 1'b0;
    #2;
    chk("mem_wr_still_waiting", {31'd0, mem_write}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_mem_write", {31'd0, mem_write}, 32'd0);
    chk("async_rst_outputs", {16'd0, got}, 32'd0);
    chk("async_rst_instret", {16'd0, instret}, 32'd0);
    chk("async_rst_instret4", {28'd0, d4_instret}, 32'd0);
    run = 1'b1;
    @(posedge clk);
    #1;
    chk("held_in_reset", {16'd0, got}, 32'd0);
    @(negedge clk);
    run = 1'b0;
    mem_ready = 1'b1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    c = 16'd0;
    add("idle_after_rst", 1'b0, 4'd0, 1'b0, 1'b1, 16'd0, 1'b0);
    add("idle_go2",       1'b1, 4'd0, 1'b0, 1'b1, 16'd0, 1'b0);
    fetch(4'b0000, 0);
    add("exec_r2", 1'b1, 4'b0000, 1'b0, 1'b1, pk(0,0,0,0,2'b00,1,2'b00,1,0,0,0,0,0,0), 1'b0);
    add("wb_r2",   1'b1, 4'b0000, 1'b0, 1'b1, pk(0,0,0,0,2'b00,0,2'b00,0,0,1,1,0,0,0), 1'b1);
    fetch(4'b1111, 0);
    for (int k = 0; k < 6; k++)
      add("halt", k[0], 4'b1111, 1'b0, 1'b1, pk(0,0,0,0,2'b00,0,2'b00,0,0,0,0,0,1,0), 1'b0);
    run_vecs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multicycle_main_control.md
Name: multicycle_main_control

Overview:
- Multicycle main control FSM for the 16-bit datapath.
- Decodes the 4-bit instruction opcode and sequences fetch, decode, execute, memory and writeback.
- Drives every datapath enable, and drives `rtype`/`beq` into the ALU control unit, which turns them plus `func` into the 4-bit ALU op.
- Handshakes with unified instruction/data memory via `mem_ready`, and counts retired instructions.

Parameters:
- CNT_W, 16, width of the retired-instruction counter `instret`.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- run  in  1  level; leave IDLE and start fetching while high
- opcode  in  4  IR[15:12], valid from DECODE onward
- zero  in  1  ALU zero flag, same-cycle combinational
- mem_ready  in  1  memory completes the current read/write this cycle
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  load IR from memory data
- pc_write  out  1  load PC
- pc_source  out  2  00 ALU result, 01 ALUOut, 10 jump target
- alu_src_a  out  1  0 PC, 1 register A
- alu_src_b  out  2  00 register B, 01 constant 1, 10 sign-extended imm
- rtype  out  1  to ALU control; 0 forces add
- beq  out  1  to ALU control; with rtype=1 forces subtract
- reg_write  out  1  register file write enable
- reg_dst  out  1  0 rt (I-type), 1 rd (R-type)
- mem_to_reg  out  1  0 ALUOut, 1 MDR
- halted  out  1  high in HALT
- illegal  out  1  one-cycle pulse on unknown opcode
- instret  out  CNT_W  retired-instruction count

Behaviour:
- Opcodes:
  - 0000 R-type
  - 0001 addi
  - 0010 lw
  - 0011 sw
  - 0100 beq
  - 0101 j
  - 1111 halt
  - others illegal
- Moore FSM; all outputs decode combinationally from the registered state, except that `pc_write` and `ir_write` in FETCH are qualified by `mem_ready`, and `pc_write` in BRANCH is qualified by `zero`.
- Any output not listed for a state is 0.
- Reset (`rst_n`=0, asynchronous): state=IDLE, `instret`=0, all outputs 0.
- IDLE: stay while `run`=0; go to FETCH when `run`=1.
- FETCH:
  - Drive `mem_read`=1, `alu_src_a`=0, `alu_src_b`=01, `rtype`=0, `pc_source`=00.
  - `ir_write` and `pc_write` equal `mem_ready`.
  - Stay until `mem_ready`=1, then go to DECODE.
- DECODE:
  - Drive `alu_src_a`=0, `alu_src_b`=10, `rtype`=0 (branch target into ALUOut).
  - Next state by opcode:
    - R-type -> EXEC_R
    - addi -> EXEC_I
    - lw/sw -> ADDR
    - beq -> BRANCH
    - j -> JUMP
    - halt -> HALT
    - illegal -> FETCH with `illegal`=1 this cycle and no retire
- EXEC_R: `alu_src_a`=1, `alu_src_b`=00, `rtype`=1, `beq`=0 -> WB_R.
- WB_R: `reg_write`=1, `reg_dst`=1, `mem_to_reg`=0, retire -> FETCH.
- EXEC_I: `alu_src_a`=1, `alu_src_b`=10, `rtype`=0 -> WB_I.
- WB_I: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=0, retire -> FETCH.
- ADDR: `alu_src_a`=1, `alu_src_b`=10, `rtype`=0.
  - lw -> MEM_RD; sw -> MEM_WR. Opcode is held stable in the IR.
- MEM_RD: `mem_read`=1; stay until `mem_ready`, then go to MEM_WB.
- MEM_WB: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=1, retire -> FETCH.
- MEM_WR: `mem_write`=1; stay until `mem_ready`, then retire -> FETCH.
- BRANCH: `alu_src_a`=1, `alu_src_b`=00, `rtype`=1, `beq`=1, `pc_source`=01, `pc_write`=`zero`; retire -> FETCH.
- JUMP: `pc_write`=1, `pc_source`=10; retire -> FETCH.
- HALT: `halted`=1; absorbing, and only reset exits. `run` is ignored after IDLE.
- Retire means `instret` increments on the clock edge leaving that state. It wraps modulo 2^CNT_W. The halt instruction itself is not counted.
- Cycle counts with zero-wait memory:
  - R/addi/lw: 4 / 4 / 5 cycles
  - sw/beq/j: 4 / 3 / 3 cycles
  - each `mem_ready`-low cycle in FETCH, MEM_RD or MEM_WR adds one cycle
- `mem_read` and `mem_write` are never high together. `reg_write` and `pc_write` are never high in the same cycle.
- Reset asserted mid-instruction (including during a memory wait) returns to IDLE immediately. No partial writes are issued after `rst_n` falls.

Test Plan:
- Reset then `run`=1, `mem_ready`=1, opcode 0000 -> states IDLE,FETCH,DECODE,EXEC_R,WB_R; `rtype`=1/`beq`=0 in EXEC_R; `reg_write`=1,`reg_dst`=1 in WB_R; `instret`=1.
- lw with `mem_ready` low 2 cycles in FETCH and 3 in MEM_RD -> `mem_read` held throughout; `pc_write` pulses once; MEM_WB `mem_to_reg`=1; total 10 cycles; `instret`+1.
- beq with `zero`=1, then beq with `zero`=0 -> BRANCH shows `rtype`=1,`beq`=1,`pc_source`=01; `pc_write`=1 then 0; both retire.
- Opcode 1010 -> `illegal` pulses 1 cycle in DECODE, returns to FETCH, `instret` unchanged; opcode 1111 -> `halted`=1 forever, `run` toggling ignored.
- CNT_W=4, 16 jumps -> `instret` wraps 15->0.
- Assert `rst_n`=0 during MEM_WR wait -> `mem_write` drops asynchronously, state IDLE, `instret`=0.
